// File: rtl/llr_pkg.sv
// Shared types and constants for the max-log LLR generator.
// Mode decode to bits-per-symbol, FSM states and symmetric saturation limits.
package llr_pkg;

  typedef enum logic [1:0] {
    Mode16Apsk = 2'd0,
    Mode32Apsk = 2'd1,
    Mode64Apsk = 2'd2,
    ModeRsvd   = 2'd3
  } mode_e;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  localparam int unsigned LlrWidth = 19;
  // -2^(L-1) is never produced so LLR magnitudes stay symmetric.
  localparam int LLR_MAX = 2 ** (LlrWidth - 1) - 1;
  localparam int LLR_MIN = -LLR_MAX;

  // Reserved mode 3 decodes like 64-APSK.
  function automatic logic [2:0] nbits(input logic [1:0] mode);
    case (mode_e'(mode))
      Mode16Apsk: nbits = 3'd4;
      Mode32Apsk: nbits = 3'd5;
      default:    nbits = 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/llr_scale_sat.sv
// Combinational LLR datapath: (m1 - m0) * scale, round half toward +inf, symmetric saturation.
module llr_scale_sat
  import llr_pkg::*;
#(
  parameter int unsigned wordlength     = 18,
  parameter int unsigned LLR_wordlength = LlrWidth,
  parameter int unsigned fraction       = 10,
  parameter int          SatMax         = LLR_MAX,
  parameter int          SatMin         = LLR_MIN
) (
  input  logic [wordlength-1:0]     m0_i,
  input  logic [wordlength-1:0]     m1_i,
  input  logic [wordlength-1:0]     scale_i,
  output logic [LLR_wordlength-1:0] llr_o
);

  localparam int unsigned PW = 2 * wordlength + 2;
  localparam logic signed [PW-1:0] RoundHalf = PW'(2 ** (fraction - 1));
  localparam logic signed [PW-1:0] SatHi     = PW'(SatMax);
  localparam logic signed [PW-1:0] SatLo     = PW'(SatMin);

  logic signed [wordlength:0] diff;
  logic signed [PW-1:0]       diff_ext;
  logic signed [PW-1:0]       scale_ext;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       rounded;

  always_comb begin
    diff      = $signed({1'b0, m1_i}) - $signed({1'b0, m0_i});
    diff_ext  = PW'(diff);
    scale_ext = $signed(PW'({1'b0, scale_i}));
    prod      = diff_ext * scale_ext;
    // Arithmetic shift floors, so adding half first rounds ties upward.
    rounded   = (prod + RoundHalf) >>> fraction;
    if (rounded > SatHi) begin
      llr_o = SatHi[LLR_wordlength-1:0];
    end else if (rounded < SatLo) begin
      llr_o = SatLo[LLR_wordlength-1:0];
    end else begin
      llr_o = rounded[LLR_wordlength-1:0];
    end
  end

endmodule

// File: rtl/llr_gen.sv
// Captures one symbol's min-metric sets and streams its scaled, saturated LLRs one per cycle
// over valid/ready, sharing a single multiplier across bit indices.
module llr_gen
  import llr_pkg::*;
#(
  parameter int unsigned wordlength     = 18,
  parameter int unsigned LLR_wordlength = LlrWidth,
  parameter int unsigned fraction       = 10,
  parameter int unsigned bit_num        = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          i_valid,
  output logic                          o_in_ready,
  input  logic [1:0]                    i_mode,
  input  logic [wordlength-1:0]         i_scale,
  input  logic [bit_num*wordlength-1:0] i_metric0,
  input  logic [bit_num*wordlength-1:0] i_metric1,
  output logic [LLR_wordlength-1:0]     o_llr,
  output logic [2:0]                    o_llr_idx,
  output logic                          o_llr_last,
  output logic                          o_llr_valid,
  input  logic                          i_llr_ready
);

  localparam int unsigned BusW   = bit_num * wordlength;
  localparam int          SatPos = 2 ** (LLR_wordlength - 1) - 1;

  state_e                    state_q, state_d;
  logic [BusW-1:0]           metric0_q, metric0_d;
  logic [BusW-1:0]           metric1_q, metric1_d;
  logic [wordlength-1:0]     scale_q, scale_d;
  logic [2:0]                nbits_q, nbits_d;
  logic [2:0]                idx_q, idx_d;
  logic [LLR_wordlength-1:0] llr_q, llr_d;
  logic [2:0]                llr_idx_q, llr_idx_d;
  logic                      llr_last_q, llr_last_d;
  logic                      llr_valid_q, llr_valid_d;

  logic [wordlength-1:0]     sel_m0, sel_m1, sel_scale;
  logic [LLR_wordlength-1:0] calc_llr;
  logic                      slot_free, last_idx, in_ready, accept, issue, bypass;

  // While idle the datapath looks at the live inputs so bit 0 can load on the accept edge.
  always_comb begin
    sel_m0    = '0;
    sel_m1    = '0;
    sel_scale = scale_q;
    if (state_q == StIdle) begin
      sel_m0    = i_metric0[wordlength-1:0];
      sel_m1    = i_metric1[wordlength-1:0];
      sel_scale = i_scale;
    end else begin
      for (int k = 0; k < int'(bit_num); k++) begin
        if (idx_q == 3'(k)) begin
          sel_m0 = metric0_q[k*wordlength +: wordlength];
          sel_m1 = metric1_q[k*wordlength +: wordlength];
        end
      end
    end
  end

  llr_scale_sat #(
    .wordlength    (wordlength),
    .LLR_wordlength(LLR_wordlength),
    .fraction      (fraction),
    .SatMax        (SatPos),
    .SatMin        (-SatPos)
  ) u_scale_sat (
    .m0_i   (sel_m0),
    .m1_i   (sel_m1),
    .scale_i(sel_scale),
    .llr_o  (calc_llr)
  );

  always_comb begin
    slot_free = !llr_valid_q || i_llr_ready;
    last_idx  = (idx_q == 3'(nbits_q - 3'd1));
    in_ready  = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        if (slot_free) begin
          issue    = 1'b1;
          in_ready = last_idx;
        end
      end
      default: ;
    endcase
    in_ready = in_ready & en;
    issue    = issue & en;
    accept   = i_valid & in_ready;
    bypass   = (state_q == StIdle) & accept & slot_free;

    state_d     = state_q;
    metric0_d   = metric0_q;
    metric1_d   = metric1_q;
    scale_d     = scale_q;
    nbits_d     = nbits_q;
    idx_d       = idx_q;
    llr_d       = llr_q;
    llr_idx_d   = llr_idx_q;
    llr_last_d  = llr_last_q;
    llr_valid_d = llr_valid_q;

    if (en) begin
      if (llr_valid_q && i_llr_ready) begin
        llr_valid_d = 1'b0;
      end
      if (issue || bypass) begin
        llr_d       = calc_llr;
        llr_idx_d   = bypass ? 3'd0 : idx_q;
        llr_last_d  = bypass ? 1'b0 : last_idx;
        llr_valid_d = 1'b1;
        idx_d       = idx_q + 3'd1;
      end
      if (accept) begin
        metric0_d = i_metric0;
        metric1_d = i_metric1;
        scale_d   = i_scale;
        nbits_d   = nbits(i_mode);
        idx_d     = bypass ? 3'd1 : 3'd0;
      end
      unique case (state_q)
        StIdle: if (accept) state_d = StRun;
        StRun:  if (issue && last_idx && !accept) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      metric0_q   <= '0;
      metric1_q   <= '0;
      scale_q     <= '0;
      nbits_q     <= '0;
      idx_q       <= '0;
      llr_q       <= '0;
      llr_idx_q   <= '0;
      llr_last_q  <= 1'b0;
      llr_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      metric0_q   <= metric0_d;
      metric1_q   <= metric1_d;
      scale_q     <= scale_d;
      nbits_q     <= nbits_d;
      idx_q       <= idx_d;
      llr_q       <= llr_d;
      llr_idx_q   <= llr_idx_d;
      llr_last_q  <= llr_last_d;
      llr_valid_q <= llr_valid_d;
    end
  end

  assign o_in_ready  = in_ready;
  assign o_llr       = llr_q;
  assign o_llr_idx   = llr_idx_q;
  assign o_llr_last  = llr_last_q;
  assign o_llr_valid = llr_valid_q;

endmodule

// File: tb/tb_llr_gen.sv
// Self-checking bench for llr_gen: directed table, corner sequences and a randomized
// run scored against a queue-based arithmetic model.
module tb_llr_gen;

  localparam int W  = 18;
  localparam int L  = 19;
  localparam int NB = 6;
  localparam int BW = NB * W;

  logic          clk, rst_n, en, i_valid, o_in_ready;
  logic [1:0]    i_mode;
  logic [W-1:0]  i_scale;
  logic [BW-1:0] i_metric0, i_metric1;
  logic [L-1:0]  o_llr;
  logic [2:0]    o_llr_idx;
  logic          o_llr_last, o_llr_valid, i_llr_ready;

  llr_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .i_mode     (i_mode),
    .i_scale    (i_scale),
    .i_metric0  (i_metric0),
    .i_metric1  (i_metric1),
    .o_llr      (o_llr),
    .o_llr_idx  (o_llr_idx),
    .o_llr_last (o_llr_last),
    .o_llr_valid(o_llr_valid),
    .i_llr_ready(i_llr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int llr;
    int idx;
    bit last;
  } exp_t;

  typedef struct {
    int       m0;
    int       m1;
    int       scale;
    bit [1:0] mode;
    int       llr;
  } vec_t;

  int    n_checks = 0;
  int    n_pass = 0;
  exp_t  expq[$];
  exp_t  mon_e;
  bit    hold_armed = 0;
  bit    rand_bp = 0;
  logic [23:0] held;
  int    run_len = 0;
  int    max_run = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Real-valued LLR = (m1-m0)*scale/1024, rounded to nearest with ties upward, clamped.
  function automatic int ref_llr(input longint m0, input longint m1, input longint sc);
    longint num, q;
    num = (m1 - m0) * sc + 512;
    q   = num / 1024;
    if (num < 0 && q * 1024 != num) q = q - 1;
    if (q > 262143) q = 262143;
    if (q < -262143) q = -262143;
    return int'(q);
  endfunction

  function automatic int ref_nbits(input int mode);
    return (mode == 0) ? 4 : (mode == 1) ? 5 : 6;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      hold_armed = 0;
      run_len = 0;
    end else begin
      if (hold_armed)
        check("hold_stable", int'({o_llr_valid, o_llr_last, o_llr_idx, o_llr}), int'(held));
      hold_armed = !en || (o_llr_valid && !i_llr_ready);
      held = {o_llr_valid, o_llr_last, o_llr_idx, o_llr};
      if (o_llr_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (en && o_llr_valid && i_llr_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_llr", 1, 0);
        end else begin
          mon_e = expq.pop_front();
          check("llr", int'($signed(o_llr)), mon_e.llr);
          check("llr_idx", int'(o_llr_idx), mon_e.idx);
          check("llr_last", int'(o_llr_last), int'(mon_e.last));
        end
      end
      if (en && i_valid && o_in_ready) begin
        for (int k = 0; k < ref_nbits(int'(i_mode)); k++) begin
          mon_e.llr  = ref_llr(longint'(i_metric0[k*W +: W]), longint'(i_metric1[k*W +: W]),
                               longint'(i_scale));
          mon_e.idx  = k;
          mon_e.last = (k == ref_nbits(int'(i_mode)) - 1);
          expq.push_back(mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) begin
      i_llr_ready = ($urandom_range(0, 9) < 7);
      en          = ($urandom_range(0, 9) != 0);
    end
  endtask

  task automatic send(input logic [BW-1:0] m0, input logic [BW-1:0] m1,
                      input logic [W-1:0] sc, input logic [1:0] mode);
    bit ok = 0;
    i_metric0 = m0;
    i_metric1 = m1;
    i_scale   = sc;
    i_mode    = mode;
    i_valid   = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (en && o_in_ready) ok = 1;
      tick();
    end
    i_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = (expq.size() == 0) && !o_llr_valid;
      tick();
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic rand_bus(output logic [BW-1:0] b);
    for (int k = 0; k < NB; k++) b[k*W +: W] = W'($urandom);
  endtask

  vec_t          vecs[9];
  logic [BW-1:0] b0, b1;
  bit            seen;

  initial begin
    vecs[0] = '{m0: 200,    m1: 500,    scale: 1024,   mode: 2'd2, llr: 300};
    vecs[1] = '{m0: 500,    m1: 200,    scale: 1536,   mode: 2'd1, llr: -450};
    vecs[2] = '{m0: 512,    m1: 0,      scale: 1,      mode: 2'd0, llr: 0};
    vecs[3] = '{m0: 0,      m1: 262143, scale: 131072, mode: 2'd3, llr: 262143};
    vecs[4] = '{m0: 262143, m1: 0,      scale: 131072, mode: 2'd2, llr: -262143};
    vecs[5] = '{m0: 0,      m1: 1,      scale: 512,    mode: 2'd0, llr: 1};
    vecs[6] = '{m0: 1,      m1: 0,      scale: 512,    mode: 2'd1, llr: 0};
    vecs[7] = '{m0: 3,      m1: 0,      scale: 512,    mode: 2'd2, llr: -1};
    vecs[8] = '{m0: 0,      m1: 1000,   scale: 100,    mode: 2'd0, llr: 98};

    rst_n = 1'b0; en = 1'b1; i_valid = 1'b0; i_llr_ready = 1'b1;
    i_mode = '0; i_scale = '0; i_metric0 = '0; i_metric1 = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(o_llr_valid), 0);
    check("rst_llr", int'(o_llr), 0);
    check("rst_idx_last", int'({o_llr_idx, o_llr_last}), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", int'(o_in_ready), 1);
    tick();

    // Directed table: every field equal so each LLR of the symbol is the table value.
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < NB; k++) begin
        b0[k*W +: W] = W'(vecs[v].m0);
        b1[k*W +: W] = W'(vecs[v].m1);
      end
      send(b0, b1, W'(vecs[v].scale), vecs[v].mode);
      @(negedge clk);
      check("tbl_valid_t1", int'(o_llr_valid), 1);
      check("tbl_llr", int'($signed(o_llr)), vecs[v].llr);
      check("tbl_idx0", int'(o_llr_idx), 0);
      tick();
      drain();
    end

    // 16-APSK then 32-APSK with i_valid held: 9 LLRs with no bubble.
    max_run = 0;
    rand_bus(b0); rand_bus(b1);
    send(b0, b1, W'(1024), 2'd0);
    rand_bus(b0); rand_bus(b1);
    send(b0, b1, W'(700), 2'd1);
    drain();
    check("b2b_run_len", max_run, 9);

    // Back-pressure for 3 cycles, then enable low for 2 cycles, mid-symbol.
    rand_bus(b0); rand_bus(b1);
    send(b0, b1, W'(2000), 2'd2);
    tick();
    i_llr_ready = 1'b0;
    repeat (3) tick();
    i_llr_ready = 1'b1;
    tick();
    en = 1'b0;
    @(negedge clk);
    check("en_low_in_ready", int'(o_in_ready), 0);
    tick();
    tick();
    en = 1'b1;
    drain();

    // Reset once bit 2 has been issued; the rest of the symbol is dropped.
    rand_bus(b0); rand_bus(b1);
    send(b0, b1, W'(3000), 2'd2);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = o_llr_valid && (o_llr_idx == 3'd2);
      tick();
    end
    check("saw_idx2", int'(seen), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", int'({o_llr_valid, o_llr_last, o_llr_idx, o_llr}), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", int'(o_in_ready), 1);
    tick();
    rand_bus(b0); rand_bus(b1);
    send(b0, b1, W'(1024), 2'd1);
    @(negedge clk);
    check("postrst_idx0", int'({o_llr_valid, o_llr_idx}), 8);
    tick();
    drain();

    // Randomized symbols, gaps, back-pressure and enable drops.
    rand_bp = 1;
    for (int s = 0; s < 40; s++) begin
      repeat ($urandom_range(0, 2)) tick();
      rand_bus(b0); rand_bus(b1);
      if (s % 4 == 0) for (int k = 0; k < NB; k++) b1[k*W +: W] = W'($urandom_range(0, 2000));
      send(b0, b1, W'($urandom_range(0, (s % 2 == 0) ? 4096 : 262143)), 2'($urandom));
    end
    rand_bp = 0;
    en = 1'b1;
    i_llr_ready = 1'b1;
    drain();
    check("queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
